instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the CPU datapath. It drives the program counter onto the instruction memory, waits for the read to complete through a request/acknowledge handshake, and loads the returned word into the instruction register. It then issues the one-cycle `REPC`/`INC` advance strobe that makes the PC/branch unit compute the next `pc` from the freshly loaded `ir_opcode`/`ir_operand_addr`. It sits between the sequencer (start/done), the instruction memory, and the PC/branch unit.

## Interface
- `IW`, 12: instruction word width; bits [11:8] are the opcode, bits [7:0] are the operand/branch offset.
- `AW`, 10: PC / instruction address width.
- `TIMEOUT`, 15: maximum WAIT cycles before a fetch error is raised; 0 disables the timeout.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  AW  current program counter from the PC/branch unit.
- `fetch_start`  in  1  sequencer request to begin a fetch; sampled only in IDLE.
- `mem_rd_req`  out  1  instruction memory read request; level-held until acknowledged.
- `mem_addr`  out  AW  read address; stable while `mem_rd_req` is high.
- `mem_rd_ack`  in  1  memory acknowledge; `mem_rd_data` is valid in the same cycle.
- `mem_rd_data`  in  IW  instruction word.
- `ir_opcode`  out  4  IR opcode field, to the decoder and the PC/branch unit.
- `ir_operand_addr`  out  8  IR operand field.
- `ir_valid`  out  1  IR holds a completed fetch.
- `REPC`  out  1  PC update enable to the PC/branch unit.
- `INC`  out  1  PC advance qualifier; always equal to `REPC`.
- `fetch_done`  out  1  one-cycle pulse marking the end of a successful fetch.
- `fetch_err`  out  1  sticky timeout flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, ADV. All outputs are registered.
- IDLE with `fetch_start`=1: `mem_addr`<=`pc`, `mem_rd_req`<=1, `ir_valid`<=0, `fetch_err`<=0, the timer is cleared, and the FSM moves to WAIT.
- WAIT with `mem_rd_ack`=1: the IR is loaded from `mem_rd_data`, `mem_rd_req`<=0, `ir_valid`<=1, `REPC`/`INC`<=1, and the FSM moves to ADV.
- WAIT with no ack: the timer increments. When it reaches `TIMEOUT` (non-zero): `mem_rd_req`<=0, `fetch_err`<=1, the IR is unchanged, no PC strobe is issued, and the FSM returns to IDLE.
- ADV: `REPC`/`INC`<=0, `fetch_done`<=1 for exactly one cycle, and the FSM returns to IDLE. The PC/branch unit updates `pc` on this same edge using the IR contents.
- `ir_valid` and the IR hold their values until the next accepted `fetch_start` or `reset`.
- `fetch_start` is ignored in WAIT and ADV. `mem_rd_ack` is ignored outside WAIT.
- If ack arrives on the same edge the timer reaches `TIMEOUT`, the ack wins: the fetch is a normal completion with no error.
- `reset` in any state: the FSM returns to IDLE immediately and all outputs go to their reset values. A read in flight is abandoned and any late ack is ignored.
- The timer saturates and never wraps. Its width is clog2(`TIMEOUT`+1), with a minimum of 1.

## Timing
- Reset values: `mem_rd_req`=0, `mem_addr`=0, `ir_opcode`=0, `ir_operand_addr`=0, `ir_valid`=0, `REPC`=0, `INC`=0, `fetch_done`=0, `fetch_err`=0, `busy`=0.
- `fetch_start` sampled at edge E0: `mem_rd_req` is high after E0.
- Ack sampled at edge Ek (k≥1): IR and `ir_valid` are valid after Ek, and `REPC`/`INC` are high during cycle Ek..Ek+1.
- `fetch_done` is high during cycle Ek+1..Ek+2. A new `fetch_start` is accepted at Ek+2 at the earliest.
- Minimum fetch is 3 edges start-to-start (ack at E1).
- Timeout: with no ack, `fetch_err` is asserted after edge E`TIMEOUT` and `mem_rd_req` falls on that same edge.

## Structure
- Opcode constants come from the shared `opcodes.vh` include (`B_OPCODE`, `BP_OPCODE`, `BN_OPCODE`, `BZ_OPCODE`, ...).
- State encodings and the IR field positions (opcode [11:8], operand [7:0]) are added to that shared header so the decoder and the fetch unit cannot disagree.
- One sub-module: `fetch_timer`, a clearable, enabled, saturating counter with a terminal-count output, parameterised by `TIMEOUT`.

## Test plan
- Reset, then `pc`=0x005, pulse `fetch_start`, ack at E1 with data 0x3A7: `mem_addr`=0x005, `ir_opcode`=0x3, `ir_operand_addr`=0xA7, `REPC`/`INC` high for 1 cycle, `fetch_done` one pulse, `busy` low after E2.
- Ack delayed to E6 with `TIMEOUT`=15: `mem_rd_req` held for 6 cycles, `mem_addr` stable throughout, `fetch_err`=0, IR correct.
- No ack with `TIMEOUT`=4: `mem_rd_req` drops and `fetch_err`=1 after E4, IR keeps its previous value, `REPC` never asserts; the next `fetch_start` clears `fetch_err`.
- Ack on the exact timeout edge (E4, `TIMEOUT`=4): normal completion, `fetch_err`=0, `REPC` pulses.
- `fetch_start` held high continuously, ack always at E1: fetches start every 3 cycles and the extra starts in WAIT/ADV are ignored; a stray ack in IDLE changes nothing.
- `reset` asserted mid-WAIT with ack arriving 1 cycle after release: all outputs at their reset values, IR stays 0, `ir_valid`=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module : instr_fetch_pkg
// Brief  : Shared opcode constants, IR field positions and fetch FSM encoding
//          used by the fetch unit and the decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam int IR_OPC_MSB  = 11;
    localparam int IR_OPC_LSB  = 8;
    localparam int IR_OPND_MSB = 7;
    localparam int IR_OPND_LSB = 0;

    localparam logic [3:0] B_OPCODE  = 4'h8;
    localparam logic [3:0] BP_OPCODE = 4'h9;
    localparam logic [3:0] BN_OPCODE = 4'hA;
    localparam logic [3:0] BZ_OPCODE = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ADV  = 2'd2
    } fetch_state_e;

    function automatic logic is_branch(input logic [3:0] opc);
        return (opc == B_OPCODE) || (opc == BP_OPCODE) ||
               (opc == BN_OPCODE) || (opc == BZ_OPCODE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_timer.sv
// ============================================================================
// Module : fetch_timer
// Brief  : Clearable, enabled, saturating counter; tc flags the enabled
//          increment that lands on TIMEOUT (never asserted when TIMEOUT is 0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   C_MAX = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != C_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (TIMEOUT != 0) && en && !clr && (count_q == C_MAX - 1'b1);

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Brief  : Fetches one instruction word via req/ack, loads the IR and issues
//          the one-cycle REPC/INC strobe to the PC/branch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int IW      = 12,
    parameter int AW      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          fetch_start,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rd_ack,
    input  logic [IW-1:0] mem_rd_data,
    output logic [3:0]    ir_opcode,
    output logic [7:0]    ir_operand_addr,
    output logic          ir_valid,
    output logic          REPC,
    output logic          INC,
    output logic          fetch_done,
    output logic          fetch_err,
    output logic          busy
);

    fetch_state_e  state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          valid_q, valid_d;
    logic          repc_q, repc_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          timer_clr;
    logic          timer_en;
    logic          timer_tc;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        valid_d   = valid_q;
        err_d     = err_q;
        repc_d    = 1'b0;
        done_d    = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    addr_d    = pc;
                    req_d     = 1'b1;
                    valid_d   = 1'b0;
                    err_d     = 1'b0;
                    timer_clr = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack on the terminal-count edge completes normally.
                if (mem_rd_ack) begin
                    ir_d    = mem_rd_data;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    repc_d  = 1'b1;
                    state_d = ST_ADV;
                end else begin
                    timer_en = 1'b1;
                    if (timer_tc) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ADV: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            repc_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            repc_q  <= repc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign mem_rd_req      = req_q;
    assign mem_addr        = addr_q;
    assign ir_opcode       = ir_q[IR_OPC_MSB:IR_OPC_LSB];
    assign ir_operand_addr = ir_q[IR_OPND_MSB:IR_OPND_LSB];
    assign ir_valid        = valid_q;
    assign REPC            = repc_q;
    assign INC             = repc_q;
    assign fetch_done      = done_q;
    assign fetch_err       = err_q;
    assign busy            = busy_q;

endmodule

`default_nettype wire
